// File: rtl/bw_seq_multiplier.sv
// Sequential Baugh-Wooley multiplier: one partial-product row per clock,
// signed or unsigned per operation, 2*WIDTH-bit product with a one-cycle valid pulse.
module bw_seq_multiplier #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 ready,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   P
);

    localparam logic [2*WIDTH-1:0] ONE_C    = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] CORR_C   = (ONE_C << WIDTH) | (ONE_C << (2*WIDTH-1));
    localparam logic [WIDTH-1:0]   MSB_C    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   LOW_C    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CW-1:0]      LAST_ROW = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     x_r;
    logic [WIDTH-1:0]     y_r;
    logic                 sgn_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        row_r;
    logic                 ready_r;
    logic                 valid_r;
    logic [2*WIDTH-1:0]   p_r;

    logic [WIDTH-1:0]     y_shift_s;
    logic [WIDTH-1:0]     pp_s;
    logic [2*WIDTH-1:0]   acc_next_s;

    // One row of Baugh-Wooley cells: AND terms, with NAND on the cells where
    // exactly one index is the sign position (the sign-by-sign cell stays AND).
    function automatic logic [WIDTH-1:0] bw_row(input logic [WIDTH-1:0] x,
                                                input logic y_bit,
                                                input logic signed_mode,
                                                input logic last_row);
        logic [WIDTH-1:0] terms;
        terms = x & {WIDTH{y_bit}};
        if (signed_mode) begin
            terms = terms ^ (last_row ? LOW_C : MSB_C);
        end else begin
            terms = terms;
        end
        return terms;
    endfunction

    // Current row's terms, aligned to weight 2^row and summed into the accumulator.
    always_comb begin
        y_shift_s  = y_r >> row_r;
        pp_s       = bw_row(x_r, y_shift_s[0], sgn_r, (row_r == LAST_ROW));
        acc_next_s = acc_r + ({{WIDTH{1'b0}}, pp_s} << row_r);
    end

    // Control FSM, operand capture, accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            x_r     <= {WIDTH{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            sgn_r   <= 1'b0;
            acc_r   <= {(2*WIDTH){1'b0}};
            row_r   <= {CW{1'b0}};
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            p_r     <= {(2*WIDTH){1'b0}};
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x_r     <= X;
                        y_r     <= Y;
                        sgn_r   <= sgn;
                        acc_r   <= {(2*WIDTH){1'b0}};
                        row_r   <= {CW{1'b0}};
                        ready_r <= 1'b0;
                        state_r <= RUN;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    acc_r <= acc_next_s;
                    if (row_r == LAST_ROW) begin
                        state_r <= FIN;
                    end else begin
                        row_r <= row_r + CW'(1);
                    end
                end
                FIN: begin
                    // Sign-mode correction folds in the constant ones of the BW array.
                    p_r     <= sgn_r ? (acc_r + CORR_C) : acc_r;
                    valid_r <= 1'b1;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign valid = valid_r;
    assign P     = p_r;

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Self-checking bench for bw_seq_multiplier: directed table, multi-cycle corner
// sequences, and random operands against a reference product (WIDTH=8 and WIDTH=5).
module tb_bw_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, sgn = 1'b0;
    logic [7:0]  x8 = 8'h00, y8 = 8'h00;
    logic        ready8, valid8;
    logic [15:0] p8;

    logic        start5 = 1'b0, sgn5 = 1'b0;
    logic [4:0]  x5 = 5'h00, y5 = 5'h00;
    logic        ready5, valid5;
    logic [9:0]  p5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bw_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .X(x8), .Y(y8),
        .ready(ready8), .valid(valid8), .P(p8)
    );

    bw_seq_multiplier #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .sgn(sgn5), .X(x5), .Y(y5),
        .ready(ready5), .valid(valid5), .P(p5)
    );

    typedef struct {
        logic        s;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_p;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        int ia, ib;
        logic [31:0] prod;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        prod = ia * ib;
        return prod[15:0];
    endfunction

    function automatic logic [9:0] ref5(input logic s, input logic [4:0] a, input logic [4:0] b);
        int ia, ib;
        logic [31:0] prod;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        prod = ia * ib;
        return prod[9:0];
    endfunction

    // Issue one operation on the 8-bit DUT (ready must be high) and wait for valid.
    task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] p, output int lat, output bit rdy_bad);
        sgn = s; x8 = a; y8 = b; start = 1'b1; rdy_bad = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; sgn = ~s; x8 = ~a; y8 = b ^ 8'h5A; lat = 0;
        while (!valid8 && lat < 40) begin
            if (ready8) rdy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        p = p8;
    endtask

    task automatic do_op5(input logic s, input logic [4:0] a, input logic [4:0] b,
                          output logic [9:0] p, output int lat);
        sgn5 = s; x5 = a; y5 = b; start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0; x5 = ~a; lat = 0;
        while (!valid5 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p = p5;
    endtask

    initial begin
        vec_t vecs[10];
        logic [15:0] p;
        logic [9:0]  q;
        int lat, pulses;
        bit rdy_bad;
        logic s;
        logic [7:0] a, b;
        logic [4:0] a5, b5;

        vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[2] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[4] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[5] = '{1'b1, 8'hFE, 8'h03, 16'hFFFA};
        vecs[6] = '{1'b0, 8'h10, 8'h10, 16'h0100};
        vecs[7] = '{1'b0, 8'h00, 8'hAB, 16'h0000};
        vecs[8] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[9] = '{1'b0, 8'h80, 8'h80, 16'h4000};

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, ready8}, 32'd1);
        check("reset_valid", {31'b0, valid8}, 32'd0);
        check("reset_p", {16'b0, p8}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].s, vecs[i].a, vecs[i].b, p, lat, rdy_bad);
            check($sformatf("vec%0d_p", i), {16'b0, p}, {16'b0, vecs[i].exp_p});
            check($sformatf("vec%0d_latency", i), lat, 32'd9);
            check($sformatf("vec%0d_ready_busy", i), {31'b0, rdy_bad}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid_pulse", i), {31'b0, valid8}, 32'd0);
            check($sformatf("vec%0d_p_held", i), {16'b0, p8}, {16'b0, vecs[i].exp_p});
        end

        // start while busy (row 3) must be ignored
        sgn = 1'b0; x8 = 8'h10; y8 = 8'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        x8 = 8'h03; y8 = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (valid8) begin
                pulses++;
                p = p8;
            end
            @(posedge clk); #1;
        end
        check("busy_start_pulses", pulses, 32'd1);
        check("busy_start_p", {16'b0, p}, 32'h0100);

        // back-to-back: second start in the valid cycle of the first
        do_op(1'b1, 8'hFF, 8'h01, p, lat, rdy_bad);
        check("b2b_first_p", {16'b0, p}, 32'hFFFF);
        check("b2b_first_ready", {31'b0, ready8}, 32'd1);
        do_op(1'b1, 8'h7F, 8'h80, p, lat, rdy_bad);
        check("b2b_second_p", {16'b0, p}, 32'hC080);
        check("b2b_second_latency", lat, 32'd9);
        @(posedge clk); #1;

        // reset in the middle of an operation
        sgn = 1'b1; x8 = 8'h7F; y8 = 8'h7F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", {31'b0, ready8}, 32'd1);
        check("abort_valid", {31'b0, valid8}, 32'd0);
        check("abort_p", {16'b0, p8}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (valid8) pulses++;
            @(posedge clk); #1;
        end
        check("abort_no_valid", pulses, 32'd0);
        do_op(1'b1, 8'hFE, 8'h03, p, lat, rdy_bad);
        check("after_abort_p", {16'b0, p}, 32'hFFFA);
        @(posedge clk); #1;

        for (int i = 0; i < 300; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            do_op(s, a, b, p, lat, rdy_bad);
            check($sformatf("rand8 s=%0d %h*%h", s, a, b), {16'b0, p}, {16'b0, ref8(s, a, b)});
            if (lat != 9) check("rand8_latency", lat, 32'd9);
        end

        for (int i = 0; i < 300; i++) begin
            s  = 1'($urandom_range(0, 1));
            a5 = 5'($urandom);
            b5 = 5'($urandom);
            do_op5(s, a5, b5, q, lat);
            check($sformatf("rand5 s=%0d %h*%h", s, a5, b5), {22'b0, q}, {22'b0, ref5(s, a5, b5)});
            if (lat != 6) check("rand5_latency", lat, 32'd6);
        end
        do_op5(1'b1, 5'h10, 5'h10, q, lat);
        check("w5_minsq_p", {22'b0, q}, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
